alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the ALU. Captures decoded operands (rs/rt data, shamt, funct, destination info) from the decode/register-read stage.
- Holds them in a 2-entry skid buffer and presents them to the ALU's src_data/tar_data/shamt/funct inputs.
- Applies operand forwarding from a later stage at capture time and while entries wait. Provides valid/ready backpressure in both directions, plus a synchronous flush.

Parameters:
- DATA_W, 32, operand width; must match the ALU data width.
- REG_AW, 5, register address width (32 registers; register 0 reads as zero).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; drops all held entries
- in_valid  input  1  upstream has an operand bundle
- in_ready  output  1  stage can accept a bundle this cycle
- in_rs_addr  input  REG_AW  source register address
- in_rt_addr  input  REG_AW  target register address
- in_rs_data  input  DATA_W  register-file value of rs
- in_rt_data  input  DATA_W  register-file value of rt
- in_shamt  input  5  shift amount
- in_funct  input  6  ALU function code
- in_rd_addr  input  REG_AW  writeback destination
- in_reg_write  input  1  instruction writes rd
- fwd_en  input  1  forwarding source valid this cycle
- fwd_addr  input  REG_AW  register being produced
- fwd_data  input  DATA_W  value being produced
- out_valid  output  1  head entry valid
- out_ready  input  1  ALU/next stage consumes head this cycle
- src_data  output  DATA_W  to ALU src_data
- tar_data  output  DATA_W  to ALU tar_data
- shamt  output  5  to ALU shamt
- funct  output  6  to ALU funct
- rd_addr  output  REG_AW  passed downstream
- reg_write  output  1  passed downstream
- illegal_funct  output  1  sticky flag (only with optional feature; tied 0 otherwise)

Behaviour:
- Storage:
  - Two entries, head (drives outputs) and skid.
  - Each entry holds valid, rs_addr, rt_addr, rs_val, rt_val, shamt, funct, rd_addr, reg_write.
- Reset (rst_n low, asynchronous): both valids 0 and all fields 0. Outputs are therefore out_valid=0, src_data=0, tar_data=0, shamt=0, funct=0, rd_addr=0, reg_write=0, illegal_funct=0, in_ready=1.
- Ready: in_ready = ~skid_valid (registered state, no combinational path from out_ready).
- Accept: push = in_valid & in_ready.
- Pop: pop = out_valid & out_ready.
- Next-state rules:
  - push, head empty: write to head.
  - push, head full, no pop: write to skid.
  - push & pop, skid empty: write to head.
  - pop, skid full: skid moves to head, skid cleared. A push cannot occur in this case because in_ready=0.
  - pop only, skid empty: head cleared.
- Latency: a bundle accepted in cycle N is visible on outputs in cycle N+1. Throughput is 1 per cycle when out_ready is held high.
- Capture forwarding:
  - If fwd_en & fwd_addr==in_rs_addr & in_rs_addr!=0, capture fwd_data as rs_val; same rule for rt.
  - Register 0 always captures 0, regardless of in_*_data or forwarding.
- Snoop forwarding: every cycle, for each valid held entry, if fwd_en & fwd_addr matches its rs_addr (≠0), rs_val←fwd_data; same for rt. A held entry being popped this cycle is not updated.
- Flush:
  - Clears both valids next edge.
  - Takes priority over push, pop and snoop.
  - in_ready is not forced low; a bundle presented during flush is dropped.
- Outputs are registered entry fields, never combinational from inputs.
- shamt and funct pass through unmodified (except under the optional feature).

Optional Feature:
- FUNCT_CHECK_EN defined:
  - On capture, in_funct outside {001001, 010010, 001010, 100010} is stored as 000000.
  - illegal_funct sets the following cycle and stays set until reset. Flush does not clear it.
- FUNCT_CHECK_EN undefined: funct is passed verbatim and illegal_funct is constant 0.

Test Plan:
- Reset: hold rst_n=0 mid-stream with out_valid=1 → outputs 0 immediately (asynchronous), in_ready=1. Release → first push of rs=5/data 0x10, rt=6/data 0x20, funct 001001 → next cycle out_valid=1, src_data=0x10, tar_data=0x20.
- Backpressure: out_ready=0, push bundles A, B → in_ready=0 after B. Raise out_ready → A, then B out in consecutive cycles, in_ready=1 again; no loss or duplication.
- Forward at capture: in_rs_addr=3, in_rs_data=0x1, fwd_en=1, fwd_addr=3, fwd_data=0xDEAD → src_data=0xDEAD.
- Register 0 forwarding: fwd_addr=0 with in_rt_addr=0, in_rt_data=0x55 → tar_data=0.
- Snoop while stalled: head holds rt=7 (value 0x2), out_ready=0, then fwd_en=1, fwd_addr=7, fwd_data=0x99 → tar_data=0x99 next cycle.
- Flush with both entries full plus simultaneous push → out_valid=0, in_ready=1 next cycle, pushed bundle never appears. With FUNCT_CHECK_EN: push funct 111111 → funct=0, illegal_funct=1 and sticky.

Source files
------------

// File: rtl/alu_operand_if.sv
// Operand-stage bus: upstream bundle with valid/ready, forwarding snoop port,
// and the downstream ALU operand bundle with valid/ready.
interface alu_operand_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) ();
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [REG_AW-1:0] in_rs_addr;
   logic [REG_AW-1:0] in_rt_addr;
   logic [DATA_W-1:0] in_rs_data;
   logic [DATA_W-1:0] in_rt_data;
   logic [4:0]        in_shamt;
   logic [5:0]        in_funct;
   logic [REG_AW-1:0] in_rd_addr;
   logic              in_reg_write;
   logic              fwd_en;
   logic [REG_AW-1:0] fwd_addr;
   logic [DATA_W-1:0] fwd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] src_data;
   logic [DATA_W-1:0] tar_data;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [REG_AW-1:0] rd_addr;
   logic              reg_write;
   logic              illegal_funct;

   modport slave (
      input  flush, in_valid, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
             in_shamt, in_funct, in_rd_addr, in_reg_write,
             fwd_en, fwd_addr, fwd_data, out_ready,
      output in_ready, out_valid, src_data, tar_data, shamt, funct,
             rd_addr, reg_write, illegal_funct
   );

   modport master (
      output flush, in_valid, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
             in_shamt, in_funct, in_rd_addr, in_reg_write,
             fwd_en, fwd_addr, fwd_data, out_ready,
      input  in_ready, out_valid, src_data, tar_data, shamt, funct,
             rd_addr, reg_write, illegal_funct
   );
endinterface

// File: rtl/alu_operand_stage.sv
// 2-entry skid buffer feeding the ALU, with capture-time and snoop forwarding.
// Optional FUNCT_CHECK_EN: illegal funct codes are zeroed and flagged (sticky).
module alu_operand_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input logic         clk,
   input logic         rst_n,
   alu_operand_if.slave bus
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs_addr;
      logic [REG_AW-1:0] rt_addr;
      logic [DATA_W-1:0] rs_val;
      logic [DATA_W-1:0] rt_val;
      logic [4:0]        shamt;
      logic [5:0]        funct;
      logic [REG_AW-1:0] rd_addr;
      logic              reg_write;
   } entry_t;

   entry_t head_r, skid_r;
   entry_t head_nxt_s, skid_nxt_s;
   entry_t head_snp_s, skid_snp_s;
   entry_t cap_s;
   logic   push_s, pop_s;

   // Register 0 is hard-wired zero; otherwise a matching forward wins over the register file.
   function automatic logic [DATA_W-1:0] pick_operand(
      input logic [REG_AW-1:0] addr,
      input logic [DATA_W-1:0] rf_data,
      input logic              fe,
      input logic [REG_AW-1:0] fa,
      input logic [DATA_W-1:0] fd
   );
      logic [DATA_W-1:0] r;
      if (addr == {REG_AW{1'b0}}) begin
         r = {DATA_W{1'b0}};
      end else if (fe && (fa == addr)) begin
         r = fd;
      end else begin
         r = rf_data;
      end
      return r;
   endfunction

   function automatic entry_t snoop(
      input entry_t            e,
      input logic              fe,
      input logic [REG_AW-1:0] fa,
      input logic [DATA_W-1:0] fd
   );
      entry_t r;
      r = e;
      if (e.valid) begin
         r.rs_val = pick_operand(e.rs_addr, e.rs_val, fe, fa, fd);
         r.rt_val = pick_operand(e.rt_addr, e.rt_val, fe, fa, fd);
      end else begin
         r = e;
      end
      return r;
   endfunction

`ifdef FUNCT_CHECK_EN
   function automatic logic funct_legal(input logic [5:0] f);
      logic ok;
      case (f)
         6'b001001, 6'b010010, 6'b001010, 6'b100010: ok = 1'b1;
         default:                                    ok = 1'b0;
      endcase
      return ok;
   endfunction
`endif

   assign push_s = bus.in_valid & ~skid_r.valid;
   assign pop_s  = head_r.valid & bus.out_ready;

   // Build the entry written on a push, forwarding applied at capture.
   always_comb begin
      cap_s           = {$bits(entry_t){1'b0}};
      cap_s.valid     = 1'b1;
      cap_s.rs_addr   = bus.in_rs_addr;
      cap_s.rt_addr   = bus.in_rt_addr;
      cap_s.rs_val    = pick_operand(bus.in_rs_addr, bus.in_rs_data, bus.fwd_en, bus.fwd_addr, bus.fwd_data);
      cap_s.rt_val    = pick_operand(bus.in_rt_addr, bus.in_rt_data, bus.fwd_en, bus.fwd_addr, bus.fwd_data);
      cap_s.shamt     = bus.in_shamt;
`ifdef FUNCT_CHECK_EN
      cap_s.funct     = funct_legal(bus.in_funct) ? bus.in_funct : 6'b000000;
`else
      cap_s.funct     = bus.in_funct;
`endif
      cap_s.rd_addr   = bus.in_rd_addr;
      cap_s.reg_write = bus.in_reg_write;
   end

   assign head_snp_s = snoop(head_r, bus.fwd_en, bus.fwd_addr, bus.fwd_data);
   assign skid_snp_s = snoop(skid_r, bus.fwd_en, bus.fwd_addr, bus.fwd_data);

   // Skid-buffer next state; a popped head is overwritten or cleared, so its snoop never lands.
   always_comb begin
      head_nxt_s = head_snp_s;
      skid_nxt_s = skid_snp_s;
      if (bus.flush) begin
         head_nxt_s = {$bits(entry_t){1'b0}};
         skid_nxt_s = {$bits(entry_t){1'b0}};
      end else if (pop_s && skid_r.valid) begin
         head_nxt_s = skid_snp_s;
         skid_nxt_s = {$bits(entry_t){1'b0}};
      end else if (push_s && (!head_r.valid || pop_s)) begin
         head_nxt_s = cap_s;
      end else if (push_s) begin
         skid_nxt_s = cap_s;
      end else if (pop_s) begin
         head_nxt_s = {$bits(entry_t){1'b0}};
      end else begin
         head_nxt_s = head_snp_s;
         skid_nxt_s = skid_snp_s;
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r <= {$bits(entry_t){1'b0}};
         skid_r <= {$bits(entry_t){1'b0}};
      end else begin
         head_r <= head_nxt_s;
         skid_r <= skid_nxt_s;
      end
   end

`ifdef FUNCT_CHECK_EN
   logic illegal_r;

   // Sticky illegal-funct flag; only reset clears it, flush does not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_r <= 1'b0;
      end else if (push_s && !bus.flush && !funct_legal(bus.in_funct)) begin
         illegal_r <= 1'b1;
      end else begin
         illegal_r <= illegal_r;
      end
   end

   assign bus.illegal_funct = illegal_r;
`else
   assign bus.illegal_funct = 1'b0;
`endif

   assign bus.in_ready  = ~skid_r.valid;
   assign bus.out_valid = head_r.valid;
   assign bus.src_data  = head_r.rs_val;
   assign bus.tar_data  = head_r.rt_val;
   assign bus.shamt     = head_r.shamt;
   assign bus.funct     = head_r.funct;
   assign bus.rd_addr   = head_r.rd_addr;
   assign bus.reg_write = head_r.reg_write;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table plus hand sequences,
// with a queue scoreboard modelling the skid buffer, forwarding and flush.
module tb_alu_operand_stage;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   alu_operand_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

   alu_operand_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [AW-1:0] rs_addr;
      logic [AW-1:0] rt_addr;
      logic [DW-1:0] src;
      logic [DW-1:0] tar;
      logic [4:0]    shamt;
      logic [5:0]    funct;
      logic [AW-1:0] rd;
      logic          rw;
   } exp_t;

   typedef struct {
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [DW-1:0] rs_d;
      logic [DW-1:0] rt_d;
      logic [5:0]    fn;
      logic          fe;
      logic [AW-1:0] fa;
      logic [DW-1:0] fd;
      logic [DW-1:0] exp_src;
      logic [DW-1:0] exp_tar;
   } vec_t;

   exp_t q[$];
   vec_t vecs[6];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [5:0] exp_funct(input logic [5:0] f);
`ifdef FUNCT_CHECK_EN
      case (f)
         6'b001001, 6'b010010, 6'b001010, 6'b100010: return f;
         default: return 6'b000000;
      endcase
`else
      return f;
`endif
   endfunction

   function automatic logic [DW-1:0] model_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (a == 5'd0) return 32'd0;
      if (bus.fwd_en && bus.fwd_addr == a) return bus.fwd_data;
      return d;
   endfunction

   // Scoreboard: compare on pop, snoop waiting entries, capture pushes.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         int   sz0;
         exp_t e;
         sz0 = q.size();
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sz0 != 0});
         chk("in_ready", {31'd0, bus.in_ready}, {31'd0, sz0 < 2});
         if (bus.flush) begin
            q.delete();
         end else begin
            if (sz0 > 0 && bus.out_ready) begin
               e = q.pop_front();
               chk("pop src_data", bus.src_data, e.src);
               chk("pop tar_data", bus.tar_data, e.tar);
               chk("pop shamt", {27'd0, bus.shamt}, {27'd0, e.shamt});
               chk("pop funct", {26'd0, bus.funct}, {26'd0, e.funct});
               chk("pop rd_addr", {27'd0, bus.rd_addr}, {27'd0, e.rd});
               chk("pop reg_write", {31'd0, bus.reg_write}, {31'd0, e.rw});
            end
            for (int i = 0; i < q.size(); i++) begin
               q[i].src = model_op(q[i].rs_addr, q[i].src);
               q[i].tar = model_op(q[i].rt_addr, q[i].tar);
            end
            if (bus.in_valid && sz0 < 2) begin
               e.rs_addr = bus.in_rs_addr;
               e.rt_addr = bus.in_rt_addr;
               e.src     = model_op(bus.in_rs_addr, bus.in_rs_data);
               e.tar     = model_op(bus.in_rt_addr, bus.in_rt_data);
               e.shamt   = bus.in_shamt;
               e.funct   = exp_funct(bus.in_funct);
               e.rd      = bus.in_rd_addr;
               e.rw      = bus.in_reg_write;
               q.push_back(e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.fwd_en   = 1'b0;
      bus.flush    = 1'b0;
   endtask

   task automatic drive(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                        input logic [5:0] fn, input logic [AW-1:0] rd);
      bus.in_valid     = 1'b1;
      bus.in_rs_addr   = rs;
      bus.in_rt_addr   = rt;
      bus.in_rs_data   = rsd;
      bus.in_rt_data   = rtd;
      bus.in_funct     = fn;
      bus.in_rd_addr   = rd;
      bus.in_shamt     = rd ^ 5'd19;
      bus.in_reg_write = rd[0];
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      chk({tag, " src_data"}, bus.src_data, 32'd0);
      chk({tag, " tar_data"}, bus.tar_data, 32'd0);
      chk({tag, " shamt"}, {27'd0, bus.shamt}, 32'd0);
      chk({tag, " funct"}, {26'd0, bus.funct}, 32'd0);
      chk({tag, " rd_addr"}, {27'd0, bus.rd_addr}, 32'd0);
      chk({tag, " reg_write"}, {31'd0, bus.reg_write}, 32'd0);
      chk({tag, " illegal_funct"}, {31'd0, bus.illegal_funct}, 32'd0);
      chk({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      vecs[0] = '{5'd5,  5'd6,  32'h10,       32'h20,  6'b001001, 1'b0, 5'd0,  32'h0,      32'h10,       32'h20};
      vecs[1] = '{5'd3,  5'd4,  32'h1,        32'h44,  6'b010010, 1'b1, 5'd3,  32'hDEAD,   32'hDEAD,     32'h44};
      vecs[2] = '{5'd0,  5'd0,  32'h77,       32'h55,  6'b001010, 1'b1, 5'd0,  32'h123,    32'h0,        32'h0};
      vecs[3] = '{5'd9,  5'd9,  32'h5,        32'h6,   6'b100010, 1'b1, 5'd9,  32'hBEEF,   32'hBEEF,     32'hBEEF};
      vecs[4] = '{5'd31, 5'd1,  32'hFFFFFFFF, 32'h0,   6'b001001, 1'b1, 5'd2,  32'h3,      32'hFFFFFFFF, 32'h0};
      vecs[5] = '{5'd7,  5'd8,  32'hA,        32'hB,   6'b010010, 1'b0, 5'd7,  32'h99,     32'hA,        32'hB};

      rst_n = 1'b0;
      idle();
      drive(5'd0, 5'd0, 32'd0, 32'd0, 6'd0, 5'd0);
      bus.in_valid  = 1'b0;
      bus.fwd_addr  = 5'd0;
      bus.fwd_data  = 32'd0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      chk_zero_outputs("reset");
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // Vector table at full throughput.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].rs, vecs[i].rt, vecs[i].rs_d, vecs[i].rt_d, vecs[i].fn, 5'(i + 1));
         bus.fwd_en   = vecs[i].fe;
         bus.fwd_addr = vecs[i].fa;
         bus.fwd_data = vecs[i].fd;
         tick();
         chk("vec out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("vec src_data", bus.src_data, vecs[i].exp_src);
         chk("vec tar_data", bus.tar_data, vecs[i].exp_tar);
      end
      idle();
      tick();

      // Backpressure: A to head, B to skid, C held off until a slot frees.
      bus.out_ready = 1'b0;
      drive(5'd1, 5'd2, 32'h1111, 32'h2222, 6'b010010, 5'd10); tick();
      drive(5'd10, 5'd11, 32'hB0, 32'hB1, 6'b001010, 5'd11); tick();
      chk("bp in_ready full", {31'd0, bus.in_ready}, 32'd0);
      chk("bp head A", bus.src_data, 32'h1111);
      drive(5'd12, 5'd13, 32'hC0, 32'hC1, 6'b100010, 5'd12); tick();
      chk("bp still full", {31'd0, bus.in_ready}, 32'd0);
      chk("bp head A held", bus.src_data, 32'h1111);
      bus.out_ready = 1'b1;
      tick();
      chk("bp head B", bus.src_data, 32'hB0);
      chk("bp in_ready free", {31'd0, bus.in_ready}, 32'd1);
      tick();
      idle();
      chk("bp head C", bus.src_data, 32'hC0);
      tick();
      chk("bp drained", {31'd0, bus.out_valid}, 32'd0);

      // Snoop forwarding into both held entries while stalled.
      bus.out_ready = 1'b0;
      drive(5'd8, 5'd7, 32'h3, 32'h2, 6'b001001, 5'd20); tick();
      drive(5'd7, 5'd9, 32'h4, 32'h9009, 6'b010010, 5'd21); tick();
      idle();
      bus.fwd_en   = 1'b1;
      bus.fwd_addr = 5'd7;
      bus.fwd_data = 32'h99;
      chk("snoop before", bus.tar_data, 32'h2);
      tick();
      chk("snoop head tar", bus.tar_data, 32'h99);
      bus.fwd_en    = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("snoop skid src", bus.src_data, 32'h99);
      tick();

      // Flush with both entries full and a bundle presented.
      bus.out_ready = 1'b0;
      drive(5'd1, 5'd1, 32'hF1, 32'hF1, 6'b001001, 5'd1); tick();
      drive(5'd2, 5'd2, 32'hF2, 32'hF2, 6'b001001, 5'd2); tick();
      chk("flush pre in_ready", {31'd0, bus.in_ready}, 32'd0);
      drive(5'd3, 5'd3, 32'hE1, 32'hE1, 6'b001001, 5'd3);
      bus.flush = 1'b1;
      tick();
      idle();
      chk("flush full out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush full in_ready", {31'd0, bus.in_ready}, 32'd1);
      // Flush with one entry while in_ready=1: the pushed bundle is dropped.
      drive(5'd4, 5'd4, 32'hF3, 32'hF3, 6'b001001, 5'd4); tick();
      drive(5'd5, 5'd5, 32'hE2, 32'hE2, 6'b001001, 5'd5);
      bus.flush = 1'b1;
      tick();
      idle();
      chk("flush push out_valid", {31'd0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;
      tick();
      chk("flush dropped", {31'd0, bus.out_valid}, 32'd0);

      // Undefined funct code.
      drive(5'd13, 5'd14, 32'h13, 32'h14, 6'b111111, 5'd6); tick();
      idle();
`ifdef FUNCT_CHECK_EN
      chk("illegal funct zeroed", {26'd0, bus.funct}, 32'd0);
      chk("illegal flag set", {31'd0, bus.illegal_funct}, 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("illegal sticky flush", {31'd0, bus.illegal_funct}, 32'd1);
      tick();
      chk("illegal sticky", {31'd0, bus.illegal_funct}, 32'd1);
`else
      chk("funct verbatim", {26'd0, bus.funct}, 32'h3F);
      chk("illegal tied low", {31'd0, bus.illegal_funct}, 32'd0);
      tick();
`endif

      // Asynchronous reset mid-stream with out_valid high.
      bus.out_ready = 1'b0;
      drive(5'd15, 5'd16, 32'hAB, 32'hCD, 6'b001001, 5'd7); tick();
      idle();
      chk("pre-reset out_valid", {31'd0, bus.out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk_zero_outputs("async reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(5'd5, 5'd6, 32'h10, 32'h20, 6'b001001, 5'd8); tick();
      idle();
      chk("post-reset out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("post-reset src_data", bus.src_data, 32'h10);
      chk("post-reset tar_data", bus.tar_data, 32'h20);
      bus.out_ready = 1'b1;
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
